// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I instruction sequencer: fetch/execute/memory/writeback FSM
// driving request/grant/valid memory ports, with registered IR, MDR, PC and retire count.
module rv_mc_sequencer #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  input  logic [ADDR_W-1:0] next_pc_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       mdr_o,
  output logic              reg_we_o,
  output logic              retire_o,
  output logic [CNT_W-1:0]  instret_o,
  output logic              halted_o,
  output logic              trap_o
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_FWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_MWAIT = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6,
    S_TRAP  = 3'd7
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [31:0]        instr_r;
  logic [31:0]        mdr_r;
  logic [CNT_W-1:0]   instret_r;
  logic               imem_req_r;
  logic               dmem_req_r;
  logic               dmem_we_r;
  logic               reg_we_r;
  logic               retire_r;
  logic               halted_r;
  logic               trap_r;

  logic               is_load_s;
  logic               is_store_s;
  logic               is_branch_s;
  logic               is_reg_s;
  logic               fetch_illegal_s;

  // Instruction class decode from the IR; legality is judged on the incoming fetch word
  always_comb begin
    is_load_s       = (instr_r[6:2] == 5'b00000);
    is_store_s      = (instr_r[6:2] == 5'b01000);
    is_branch_s     = (instr_r[6:2] == 5'b11000);
    is_reg_s        = (instr_r[1:0] == 2'b11) && !is_load_s && !is_store_s && !is_branch_s;
    fetch_illegal_s = (imem_rdata_i[1:0] != 2'b11);
  end

  // Next-state logic; a grant only counts while our own request is actually up
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (imem_req_r && imem_gnt_i) next_state_s = S_FWAIT;
        else                          next_state_s = S_FETCH;
      end
      S_FWAIT: begin
        if (imem_rvalid_i) next_state_s = fetch_illegal_s ? S_TRAP : S_EXEC;
        else               next_state_s = S_FWAIT;
      end
      S_EXEC: begin
        if (is_load_s || is_store_s) next_state_s = S_MEM;
        else                         next_state_s = S_WB;
      end
      S_MEM: begin
        if (dmem_gnt_i) next_state_s = is_store_s ? S_WB : S_MWAIT;
        else            next_state_s = S_MEM;
      end
      S_MWAIT: begin
        if (dmem_rvalid_i) next_state_s = S_WB;
        else               next_state_s = S_MWAIT;
      end
      S_WB: begin
        if (next_pc_i[1:0] != 2'b00) next_state_s = S_TRAP;
        else if (halt_i)             next_state_s = S_HALT;
        else                         next_state_s = S_FETCH;
      end
      S_HALT: begin
        if (halt_i) next_state_s = S_HALT;
        else        next_state_s = S_FETCH;
      end
      S_TRAP:  next_state_s = S_TRAP;
      default: next_state_s = S_TRAP;
    endcase
  end

  // State, architectural registers and Moore outputs decoded from the state being entered
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r    <= S_FETCH;
      pc_r       <= RESET_PC;
      instr_r    <= 32'd0;
      mdr_r      <= 32'd0;
      instret_r  <= {CNT_W{1'b0}};
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
      reg_we_r   <= 1'b0;
      retire_r   <= 1'b0;
      halted_r   <= 1'b0;
      trap_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      imem_req_r <= (next_state_s == S_FETCH);
      dmem_req_r <= (next_state_s == S_MEM);
      dmem_we_r  <= (next_state_s == S_MEM) && is_store_s;
      reg_we_r   <= (next_state_s == S_WB) && (is_load_s || is_reg_s);
      retire_r   <= (next_state_s == S_WB);
      halted_r   <= (next_state_s == S_HALT);
      trap_r     <= (next_state_s == S_TRAP);
      if (state_r == S_FWAIT && imem_rvalid_i) instr_r <= imem_rdata_i;
      if (state_r == S_MWAIT && dmem_rvalid_i) mdr_r <= dmem_rdata_i;
      if (state_r == S_WB) begin
        pc_r      <= next_pc_i;
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign imem_req_o  = imem_req_r;
  assign imem_addr_o = pc_r;
  assign dmem_req_o  = dmem_req_r;
  assign dmem_we_o   = dmem_we_r;
  assign pc_o        = pc_r;
  assign instr_o     = instr_r;
  assign mdr_o       = mdr_r;
  assign reg_we_o    = reg_we_r;
  assign retire_o    = retire_r;
  assign instret_o   = instret_r;
  assign halted_o    = halted_r;
  assign trap_o      = trap_r;

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed self-checking bench for rv_mc_sequencer (CNT_W = 4 so the retire counter wraps quickly).
module tb_rv_mc_sequencer;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i = 1'b0;
  logic              imem_rvalid_i = 1'b0;
  logic [31:0]       imem_rdata_i = 32'd0;
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic              dmem_gnt_i = 1'b0;
  logic              dmem_rvalid_i = 1'b0;
  logic [31:0]       dmem_rdata_i = 32'd0;
  logic [ADDR_W-1:0] next_pc_i = 16'h0000;
  logic              halt_i = 1'b0;
  logic [ADDR_W-1:0] pc_o;
  logic [31:0]       instr_o;
  logic [31:0]       mdr_o;
  logic              reg_we_o;
  logic              retire_o;
  logic [CNT_W-1:0]  instret_o;
  logic              halted_o;
  logic              trap_o;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h00002103;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00000463;

  rv_mc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .next_pc_i(next_pc_i), .halt_i(halt_i), .pc_o(pc_o), .instr_o(instr_o), .mdr_o(mdr_o),
    .reg_we_o(reg_we_o), .retire_o(retire_o), .instret_o(instret_o),
    .halted_o(halted_o), .trap_o(trap_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the DUT in FETCH with the request already raised (cycle 1 of an instruction).
  task automatic do_reset();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    halt_i = 1'b0; reset_i = 1'b0;
    step(); step();
    reset_i = 1'b1;
    step();
  endtask

  // Zero-wait fetch: grant in cycle 1, rvalid in cycle 2; returns in cycle 3.
  task automatic fetch(input logic [31:0] ins);
    imem_gnt_i = 1'b1; step(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = ins; step(); imem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    imem_gnt_i = 1'b1;
    reset_i = 1'b0;
    step(); step();
    checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h expected 0000", pc_o); end
    checks++; if (instr_o !== 32'd0) begin errors++; $display("FAIL rst_ir: got %h expected 0", instr_o); end
    checks++; if (mdr_o !== 32'd0 || instret_o !== 4'd0) begin errors++; $display("FAIL rst_mdr_cnt: got %h/%h expected 0/0", mdr_o, instret_o); end
    checks++;
    if ({imem_req_o, dmem_req_o, dmem_we_o, reg_we_o, retire_o, halted_o, trap_o} !== 7'b0) begin
      errors++; $display("FAIL rst_outs: got %b expected 0000000",
        {imem_req_o, dmem_req_o, dmem_we_o, reg_we_o, retire_o, halted_o, trap_o});
    end
    reset_i = 1'b1; imem_gnt_i = 1'b0;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin errors++; $display("FAIL rst_req: got %b/%h expected 1/0000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reg();
    do_reset();
    next_pc_i = 16'h0004;
    fetch(I_ADDI);
    checks++; if (instr_o !== I_ADDI || retire_o !== 1'b0) begin errors++; $display("FAIL reg_exec: got ir=%h ret=%b expected %h/0", instr_o, retire_o, I_ADDI); end
    step();
    checks++; if (reg_we_o !== 1'b1 || retire_o !== 1'b1) begin errors++; $display("FAIL reg_wb: got we=%b ret=%b expected 1/1", reg_we_o, retire_o); end
    checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL reg_pc_hold: got %h expected 0000", pc_o); end
    step();
    checks++; if (pc_o !== 16'h0004 || instret_o !== 4'd1) begin errors++; $display("FAIL reg_pc_cnt: got %h/%0d expected 0004/1", pc_o, instret_o); end
    checks++; if (reg_we_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0004) begin errors++; $display("FAIL reg_next: got we=%b req=%b addr=%h expected 0/1/0004", reg_we_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_load_wait();
    do_reset();
    next_pc_i = 16'h0004;
    fetch(I_LW);
    step();
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0) begin errors++; $display("FAIL ld_mem: got req=%b we=%b expected 1/0", dmem_req_o, dmem_we_o); end
    step(); step(); step();
    checks++; if (dmem_req_o !== 1'b1 || retire_o !== 1'b0) begin errors++; $display("FAIL ld_gntwait: got req=%b ret=%b expected 1/0", dmem_req_o, retire_o); end
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    checks++; if (dmem_req_o !== 1'b0 || mdr_o !== 32'd0 || reg_we_o !== 1'b0) begin errors++; $display("FAIL ld_mwait: got req=%b mdr=%h we=%b expected 0/0/0", dmem_req_o, mdr_o, reg_we_o); end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF; step(); dmem_rvalid_i = 1'b0;
    checks++; if (mdr_o !== 32'hDEADBEEF || reg_we_o !== 1'b1 || retire_o !== 1'b1) begin errors++; $display("FAIL ld_wb9: got mdr=%h we=%b ret=%b expected deadbeef/1/1", mdr_o, reg_we_o, retire_o); end
    step();
    checks++; if (reg_we_o !== 1'b0 || pc_o !== 16'h0004 || instret_o !== 4'd1) begin errors++; $display("FAIL ld_after: got we=%b pc=%h cnt=%0d expected 0/0004/1", reg_we_o, pc_o, instret_o); end
  endtask

  task automatic test_store_branch();
    do_reset();
    next_pc_i = 16'h0004;
    fetch(I_SW);
    step();
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin errors++; $display("FAIL st_mem: got req=%b we=%b expected 1/1", dmem_req_o, dmem_we_o); end
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    checks++; if (retire_o !== 1'b1 || reg_we_o !== 1'b0 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL st_wb: got ret=%b we=%b req=%b expected 1/0/0", retire_o, reg_we_o, dmem_req_o); end
    step();
    next_pc_i = 16'h0010;
    fetch(I_BEQ);
    step();
    checks++; if (retire_o !== 1'b1 || reg_we_o !== 1'b0 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL br_wb: got ret=%b we=%b dreq=%b expected 1/0/0", retire_o, reg_we_o, dmem_req_o); end
    step();
    checks++; if (pc_o !== 16'h0010 || instret_o !== 4'd2) begin errors++; $display("FAIL br_pc: got %h/%0d expected 0010/2", pc_o, instret_o); end
  endtask

  task automatic test_traps();
    int bad;
    do_reset();
    next_pc_i = 16'h0004;
    fetch(32'h00000000);
    checks++; if (trap_o !== 1'b1 || retire_o !== 1'b0) begin errors++; $display("FAIL trap_ill: got trap=%b ret=%b expected 1/0", trap_o, retire_o); end
    bad = 0;
    imem_gnt_i = 1'b1; dmem_gnt_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req_o !== 1'b0 || dmem_req_o !== 1'b0 || trap_o !== 1'b1) bad++;
    end
    imem_gnt_i = 1'b0; dmem_gnt_i = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL trap_quiet: got %0d bad cycles expected 0", bad); end
    checks++; if (instret_o !== 4'd0 || pc_o !== 16'h0000) begin errors++; $display("FAIL trap_state: got cnt=%0d pc=%h expected 0/0000", instret_o, pc_o); end

    do_reset();
    next_pc_i = 16'h0006;
    fetch(I_ADDI);
    step();
    checks++; if (trap_o !== 1'b0 || retire_o !== 1'b1) begin errors++; $display("FAIL mis_wb: got trap=%b ret=%b expected 0/1", trap_o, retire_o); end
    step();
    checks++; if (trap_o !== 1'b1 || pc_o !== 16'h0006 || instret_o !== 4'd1 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL mis_trap: got trap=%b pc=%h cnt=%0d req=%b expected 1/0006/1/0", trap_o, pc_o, instret_o, imem_req_o);
    end
  endtask

  task automatic test_halt();
    do_reset();
    next_pc_i = 16'h0004;
    imem_gnt_i = 1'b1; step(); imem_gnt_i = 1'b0;
    halt_i = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = I_ADDI; step(); imem_rvalid_i = 1'b0;
    step();
    checks++; if (retire_o !== 1'b1 || halted_o !== 1'b0) begin errors++; $display("FAIL halt_wb: got ret=%b halted=%b expected 1/0", retire_o, halted_o); end
    step(); step(); step();
    checks++; if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 16'h0004 || instret_o !== 4'd1) begin
      errors++; $display("FAIL halt_hold: got halted=%b req=%b pc=%h cnt=%0d expected 1/0/0004/1", halted_o, imem_req_o, pc_o, instret_o);
    end
    halt_i = 1'b0;
    step();
    checks++; if (halted_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0004) begin errors++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected 0/1/0004", halted_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      next_pc_i = 16'((i + 1) * 4);
      fetch(I_ADDI);
      step(); step();
    end
    checks++; if (instret_o !== 4'd1 || pc_o !== 16'h0044) begin errors++; $display("FAIL wrap: got cnt=%0d pc=%h expected 1/0044", instret_o, pc_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_pc_i = 16'h0008;
    fetch(I_LW);
    step();
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678; step(); dmem_rvalid_i = 1'b0;
    step();
    checks++; if (mdr_o !== 32'h12345678 || pc_o !== 16'h0008) begin errors++; $display("FAIL rm_pre: got mdr=%h pc=%h expected 12345678/0008", mdr_o, pc_o); end
    fetch(I_LW);
    step();
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    step(); step();
    dmem_rvalid_i = 1'b0;
    checks++; if (pc_o !== 16'h0000 || mdr_o !== 32'd0 || instret_o !== 4'd0) begin errors++; $display("FAIL rm_state: got pc=%h mdr=%h cnt=%0d expected 0000/0/0", pc_o, mdr_o, instret_o); end
    checks++; if (imem_req_o !== 1'b1 || dmem_req_o !== 1'b0 || retire_o !== 1'b0) begin errors++; $display("FAIL rm_fetch: got ireq=%b dreq=%b ret=%b expected 1/0/0", imem_req_o, dmem_req_o, retire_o); end
  endtask

  initial begin
    test_reset();
    test_reg();
    test_load_wait();
    test_store_branch();
    test_traps();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
